// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Load-use / control / atomic hazard unit for a multicore MIPS pipeline.
//   It tracks in-flight load destinations for LOAD_LAT cycles after they leave
//   ID/EX and raises load-use stalls from that state. Taken branches and jumps
//   become IF/ID + ID/EX flushes. A two-state FSM freezes the pipeline across
//   LL/SC until the memory stage acknowledges, or until a forced timeout release.
//
//   Optional build macro: HAZARD_STATS_EN adds saturating event counters.
//
// Ports
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   ifid_rs/rt(_used)   decode-stage source registers and their read enables
//   idex_*              ID/EX instruction attributes (valid, dest, load, atomic,
//                       branch/BEQ, jump)
//   alu_zero            ALU zero flag for the ID/EX instruction
//   dmem_ack            memory stage finished its data access
//   lw_stall            hold PC and IF/ID, bubble into ID/EX (combinational)
//   flush_ifid/idex     discard IF/ID and ID/EX this cycle (combinational)
//   atom_hold           freeze all stages except memory (registered)
//   pend_mask           valid bits of the scoreboard slots
//   stall_cnt, flush_cnt, tmo_cnt   event counters (HAZARD_STATS_EN only)
//
// FSM states
//   IDLE      | normal operation, no hold
//   ATOM_WAIT | LL/SC in flight; atom_hold high, timeout counter running

module hazard_scoreboard #(
    parameter int REGW     = 5,
    parameter int LOAD_LAT = 2,
    parameter int ATOM_TMO = 15
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [REGW-1:0]     ifid_rs,
    input  logic [REGW-1:0]     ifid_rt,
    input  logic                ifid_rs_used,
    input  logic                ifid_rt_used,
    input  logic                idex_valid,
    input  logic [REGW-1:0]     idex_wsel,
    input  logic                idex_dren,
    input  logic                idex_datomic,
    input  logic                idex_branch,
    input  logic                idex_beq,
    input  logic                alu_zero,
    input  logic                idex_jump,
    input  logic                dmem_ack,
    output logic                lw_stall,
    output logic                flush_ifid,
    output logic                flush_idex,
    output logic                atom_hold,
    output logic [LOAD_LAT-1:0] pend_mask
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         flush_cnt,
    output logic [15:0]         tmo_cnt
`endif
);

    localparam int CNTW = $clog2(ATOM_TMO + 1);

    typedef enum logic {
        IDLE,
        ATOM_WAIT
    } state_t;

    state_t              state;
    logic [CNTW-1:0]     tmo;
    logic [LOAD_LAT-1:0] slot_v;
    logic [REGW-1:0]     slot_w [LOAD_LAT];

    logic taken;
    logic idex_ld;
    logic hazard;
    logic atom_enter;
    logic tmo_hit;

    // Register 0 is hardwired to zero, so a source of 0 never creates a hazard.
    function automatic logic src_hit(input logic [REGW-1:0] w,
                                     input logic [REGW-1:0] rs,
                                     input logic            rs_u,
                                     input logic [REGW-1:0] rt,
                                     input logic            rt_u);
        return (rs_u && (rs != '0) && (rs == w)) ||
               (rt_u && (rt != '0) && (rt == w));
    endfunction

    assign taken = idex_valid &
                   (idex_jump | (idex_branch & (idex_beq ? alu_zero : ~alu_zero)));

    // A load to $0 produces nothing worth waiting for.
    assign idex_ld = idex_valid & idex_dren & (idex_wsel != '0);

    // The oldest slot is only tracked for pend_mask: by then its data is
    // forwardable, so it no longer contributes to the hazard.
    always_comb begin
        hazard = 1'b0;
        if (idex_ld && src_hit(idex_wsel, ifid_rs, ifid_rs_used, ifid_rt, ifid_rt_used))
            hazard = 1'b1;
        for (int k = 0; k < LOAD_LAT - 1; k++) begin
            if (slot_v[k] && src_hit(slot_w[k], ifid_rs, ifid_rs_used, ifid_rt, ifid_rt_used))
                hazard = 1'b1;
        end
    end

    assign lw_stall   = hazard & ~taken & ~atom_hold;
    assign flush_ifid = taken;
    assign flush_idex = taken;
    assign pend_mask  = slot_v;

    assign atom_enter = idex_valid & idex_datomic & ~taken;
    assign tmo_hit    = (tmo == CNTW'(ATOM_TMO));

    // Scoreboard shift register; frozen while the atomic hold is active so the
    // hazard is re-evaluated against the same slots after release.
    always_ff @(posedge CLK) begin
        if (RST) begin
            slot_v <= '0;
            for (int i = 0; i < LOAD_LAT; i++)
                slot_w[i] <= '0;
        end else if (!atom_hold) begin
            slot_v[0] <= idex_ld;
            slot_w[0] <= idex_wsel;
            for (int i = 1; i < LOAD_LAT; i++) begin
                slot_v[i] <= slot_v[i-1];
                slot_w[i] <= slot_w[i-1];
            end
        end
    end

    // Atomic FSM. The counter stops at ATOM_TMO because that value forces the
    // exit, so it cannot wrap. An ack in the entry cycle is seen while still in
    // IDLE and therefore ignored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            atom_hold <= 1'b0;
            tmo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (atom_enter) begin
                        state     <= ATOM_WAIT;
                        atom_hold <= 1'b1;
                        tmo       <= '0;
                    end
                end
                ATOM_WAIT: begin
                    if (dmem_ack || tmo_hit) begin
                        state     <= IDLE;
                        atom_hold <= 1'b0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    atom_hold <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic tmo_forced;

    // An ack arriving on the last allowed cycle counts as a normal completion.
    assign tmo_forced = (state == ATOM_WAIT) & tmo_hit & ~dmem_ack;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            tmo_cnt   <= '0;
        end else begin
            if (lw_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (taken && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
            if (tmo_forced && (tmo_cnt != '1))
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed bench for hazard_scoreboard with default parameters
//   (REGW=5, LOAD_LAT=2, ATOM_TMO=15). Each driven cycle queues its expected
//   output vector {lw_stall, flush_ifid, flush_idex, atom_hold, pend_mask};
//   a monitor pops and compares on the falling edge.

module tb_hazard_scoreboard;

    localparam int REGW     = 5;
    localparam int LOAD_LAT = 2;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [REGW-1:0] rs, rt, ws;
    logic            rsu, rtu, iv, ld, at, br, beq, az, jp, ack;
    logic            lw_stall, flush_ifid, flush_idex, atom_hold;
    logic [LOAD_LAT-1:0] pend_mask;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic [15:0] tmo_cnt;
`endif

    typedef struct {
        string      nm;
        logic [5:0] v;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 CLK = ~CLK;

    hazard_scoreboard dut (
        .CLK          (CLK),
        .RST          (RST),
        .ifid_rs      (rs),
        .ifid_rt      (rt),
        .ifid_rs_used (rsu),
        .ifid_rt_used (rtu),
        .idex_valid   (iv),
        .idex_wsel    (ws),
        .idex_dren    (ld),
        .idex_datomic (at),
        .idex_branch  (br),
        .idex_beq     (beq),
        .alu_zero     (az),
        .idex_jump    (jp),
        .dmem_ack     (ack),
        .lw_stall     (lw_stall),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .atom_hold    (atom_hold),
        .pend_mask    (pend_mask)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .tmo_cnt      (tmo_cnt)
`endif
    );

    task automatic idle_inputs();
        rs = '0; rt = '0; ws = '0;
        rsu = 0; rtu = 0; iv = 0; ld = 0; at = 0;
        br = 0; beq = 0; az = 0; jp = 0; ack = 0;
    endtask

    // Start a new cycle: just after the rising edge, idle everything.
    task automatic nxt();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle_inputs();
    endtask

    task automatic chk(input string nm, input logic [5:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        q.push_back(e);
    endtask

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // Monitor: one output vector per cycle, sampled mid-cycle.
    initial begin
        exp_t       e;
        logic [5:0] got;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {lw_stall, flush_ifid, flush_idex, atom_hold, pend_mask};
                n_total++;
                if (got === e.v) n_pass++;
                else $display("FAIL %s: got %b expected %b (stall,fi,fe,hold,pend)",
                              e.nm, got, e.v);
            end
        end
    end

    initial begin
        idle_inputs();
        RST = 1'b1;
        repeat (2) @(posedge CLK);

        nxt(); chk("reset", 6'b000000);

        // Load-use on rs: ID/EX term then slot 0 -> two stall cycles.
        nxt(); iv = 1; ws = 5; ld = 1; rs = 5; rsu = 1; chk("lu_idex", 6'b100000);
        nxt(); rs = 5; rsu = 1;                         chk("lu_slot0", 6'b100001);
        nxt(); rs = 5; rsu = 1;                         chk("lu_slot1_clear", 6'b000010);
        nxt();                                          chk("lu_drain", 6'b000000);

        // Source $0 never matches; load to $0 is never recorded.
        nxt(); iv = 1; ws = 5; ld = 1; rsu = 1; rtu = 1; chk("r0_idex", 6'b000000);
        nxt(); rsu = 1; rtu = 1;                         chk("r0_slot0", 6'b000001);
        nxt();                                           chk("r0_slot1", 6'b000010);
        nxt(); iv = 1; ws = 0; ld = 1; rsu = 1;          chk("ld_r0", 6'b000000);
        nxt();                                           chk("ld_r0_slot", 6'b000000);

        // rt path and its enable; non-load producer never stalls.
        nxt(); iv = 1; ws = 7; ld = 1; rs = 3; rsu = 1; rt = 7; chk("rt_unused", 6'b000000);
        nxt(); rt = 7; rtu = 1;                          chk("rt_slot0", 6'b100001);
        nxt();                                           chk("rt_slot1", 6'b000010);
        nxt(); iv = 1; ws = 7; rt = 7; rtu = 1;          chk("alu_noload", 6'b000000);

        // Control resolution.
        nxt(); iv = 1; ws = 9; ld = 1; rs = 1; rsu = 1;  chk("br_ld", 6'b000000);
        nxt(); iv = 1; br = 1; rs = 9; rsu = 1;          chk("bne_flush", 6'b011001);
        nxt();                                           chk("bne_after", 6'b000010);
        nxt(); iv = 1; br = 1; beq = 1;                  chk("beq_nt", 6'b000000);
        nxt(); iv = 1; br = 1; az = 1;                   chk("bne_nt", 6'b000000);
        nxt(); iv = 1; br = 1; beq = 1; az = 1;          chk("beq_t", 6'b011000);
        nxt(); iv = 1; jp = 1;                           chk("jump", 6'b011000);
        nxt(); jp = 1; br = 1; beq = 1; az = 1;          chk("ctl_invalid", 6'b000000);
        nxt(); iv = 1; at = 1; jp = 1;                   chk("sc_flushed", 6'b011000);
        nxt();                                           chk("sc_flushed_nohold", 6'b000000);

        // LL with ack after 4 wait cycles; slots frozen, stall suppressed.
        nxt(); iv = 1; ws = 4; ld = 1;                   chk("at_ld", 6'b000000);
        nxt(); iv = 1; ws = 6; ld = 1; at = 1; ack = 1;  chk("ll_enter", 6'b000001);
        for (int i = 0; i < 3; i++) begin
            nxt(); rs = 6; rsu = 1;                      chk("ll_wait", 6'b000111);
        end
        nxt(); rs = 6; rsu = 1; ack = 1;                 chk("ll_wait_ack", 6'b000111);
        nxt(); rs = 6; rsu = 1;                          chk("ll_release_stall", 6'b100011);
        nxt();                                           chk("ll_drain1", 6'b000010);
        nxt();                                           chk("ll_drain2", 6'b000000);

        // SC without ack: 16 hold cycles then forced release.
        nxt(); iv = 1; at = 1;                           chk("sc_enter", 6'b000000);
        for (int i = 0; i < 16; i++) begin
            nxt();                                       chk("sc_tmo_wait", 6'b000100);
        end
        nxt();                                           chk("sc_tmo_release", 6'b000000);
`ifdef HAZARD_STATS_EN
        @(negedge CLK);
        cmp("stall_cnt", stall_cnt, 32'd4);
        cmp("flush_cnt", flush_cnt, 32'd4);
        cmp("tmo_cnt", {16'd0, tmo_cnt}, 32'd1);
`endif

        // Reset in the middle of ATOM_WAIT with valid slots.
        nxt(); iv = 1; ws = 8; ld = 1;                   chk("rst_ld", 6'b000000);
        nxt(); iv = 1; ws = 2; ld = 1; at = 1;           chk("rst_ll", 6'b000001);
        nxt();                                           chk("rst_wait", 6'b000111);
        nxt(); RST = 1;                                  chk("rst_assert", 6'b000111);
        nxt();                                           chk("rst_after", 6'b000000);
        nxt();                                           chk("rst_after2", 6'b000000);
`ifdef HAZARD_STATS_EN
        @(negedge CLK);
        cmp("stats_rst", stall_cnt | flush_cnt | {16'd0, tmo_cnt}, 32'd0);
`endif

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
